hwpe_ctrl_uloop_issuer: RTL and testbench

Control stage directly downstream of the HWPE microcode loop unit. It steps the uloop one iteration at a time and captures the per-iteration offset registers. For each iteration it adds the offsets to per-stream base addresses and issues one address request per enabled streamer on a valid/ready handshake. It signals completion when the uloop reports done and the last iteration has been accepted.

---
 rtl/hwpe_ctrl_uloop_issuer.sv | 171 +++++++++++++++++
 tb/tb_hwpe_ctrl_uloop_issuer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_uloop_issuer.sv
// hwpe_ctrl_uloop_issuer
// Steps the HWPE microcode loop one iteration at a time, captures the
// per-iteration offsets and turns them into one address request per enabled
// streamer (base + offset). Completion is flagged once the uloop has reported
// done and the final iteration has been fully accepted by the streamers.
module hwpe_ctrl_uloop_issuer #(
    parameter int unsigned NB_STREAMS = 4,
    parameter int unsigned NB_REG     = 4,
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ITER_WIDTH = 16,
    parameter int unsigned NB_LOOPS   = 6,
    localparam int unsigned LOOP_W    = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    input  logic                             start_i,
    input  logic [NB_STREAMS-1:0]            stream_mask_i,
    input  logic [NB_STREAMS*ADDR_WIDTH-1:0] base_addr_i,
    output logic                             uloop_clear_o,
    output logic                             uloop_enable_o,
    input  logic                             uloop_valid_i,
    input  logic                             uloop_done_i,
    input  logic [NB_REG*REG_WIDTH-1:0]      uloop_offs_i,
    input  logic [LOOP_W-1:0]                uloop_loop_i,
    output logic [NB_STREAMS-1:0]            req_valid_o,
    input  logic [NB_STREAMS-1:0]            req_ready_i,
    output logic [NB_STREAMS*ADDR_WIDTH-1:0] req_addr_o,
    output logic [LOOP_W-1:0]                req_loop_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [ITER_WIDTH-1:0]            iter_cnt_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FETCH  = 3'd2,
        ISSUE  = 3'd3,
        FINISH = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [NB_STREAMS-1:0]                 mask_q;
    logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0] base_q;
    logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0] offs_q;
    logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0] offs_fit;
    logic                                  ldone_q;
    logic [LOOP_W-1:0]                     loop_q;
    logic [ITER_WIDTH-1:0]                 iter_q;
    logic [NB_STREAMS-1:0]                 acc_q, acc_d;

    logic latch_job;
    logic capture;
    logic iter_inc;

    // Address generation silently wraps modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] add_wrap(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [ADDR_WIDTH-1:0] offs
    );
        return base + offs;
    endfunction

    // Offset registers are resized to the address width: truncated when wider,
    // zero-extended when narrower. Only the first NB_STREAMS registers are used.
    for (genvar s = 0; s < NB_STREAMS; s++) begin : g_offs
        if (REG_WIDTH >= ADDR_WIDTH) begin : g_trunc
            assign offs_fit[s] = uloop_offs_i[s*REG_WIDTH +: ADDR_WIDTH];
        end else begin : g_zext
            assign offs_fit[s] = {{(ADDR_WIDTH-REG_WIDTH){1'b0}},
                                  uloop_offs_i[s*REG_WIDTH +: REG_WIDTH]};
        end
        assign req_addr_o[s*ADDR_WIDTH +: ADDR_WIDTH] = add_wrap(base_q[s], offs_q[s]);
    end

    assign req_loop_o = loop_q;
    assign iter_cnt_o = iter_q;

    // State, job context, captured iteration and acceptance tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            base_q  <= '0;
            offs_q  <= '0;
            ldone_q <= 1'b0;
            loop_q  <= '0;
            iter_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            if (latch_job) begin
                mask_q <= stream_mask_i;
                base_q <= base_addr_i;
                iter_q <= '0;
            end else if (iter_inc) begin
                iter_q <= iter_q + ITER_WIDTH'(1);
            end
            if (capture) begin
                offs_q  <= offs_fit;
                ldone_q <= uloop_done_i;
                loop_q  <= uloop_loop_i;
            end
        end
    end

    // Next-state logic and handshake outputs; a soft clear overrides everything.
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        uloop_clear_o  = 1'b0;
        uloop_enable_o = 1'b0;
        req_valid_o    = '0;
        done_o         = 1'b0;
        busy_o         = (state_q != IDLE);
        latch_job      = 1'b0;
        capture        = 1'b0;
        iter_inc       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    latch_job = 1'b1;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                uloop_clear_o = 1'b1;
                state_d       = FETCH;
            end
            FETCH: begin
                // Enable drops in the capture cycle so the uloop holds this iteration.
                if (uloop_valid_i) begin
                    capture = 1'b1;
                    state_d = ISSUE;
                end else begin
                    uloop_enable_o = 1'b1;
                end
            end
            ISSUE: begin
                req_valid_o = mask_q & ~acc_q;
                acc_d       = acc_q | (req_valid_o & req_ready_i);
                if (&(acc_d | ~mask_q)) begin
                    acc_d    = '0;
                    iter_inc = 1'b1;
                    state_d  = ldone_q ? FINISH : FETCH;
                end
            end
            FINISH: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear_i) begin
            state_d   = IDLE;
            acc_d     = '0;
            latch_job = 1'b0;
            capture   = 1'b0;
            iter_inc  = 1'b0;
        end
    end

endmodule

// File: tb/tb_hwpe_ctrl_uloop_issuer.sv
// Self-checking bench for hwpe_ctrl_uloop_issuer: a behavioural uloop and
// streamer sinks drive the DUT, observed requests are compared to base+offset
// sequences computed directly from the job tables.
module tb_hwpe_ctrl_uloop_issuer;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int RW = 32;
    localparam int IW = 16;
    localparam int NL = 6;
    localparam int LW = 3;
    localparam int MAXIT = 8;

    logic            clk = 1'b0;
    logic            rst_i, clear_i, start_i;
    logic [NS-1:0]   stream_mask_i;
    logic [NS*AW-1:0] base_addr_i;
    logic            uloop_clear_o, uloop_enable_o;
    logic            uloop_valid_i, uloop_done_i;
    logic [NS*RW-1:0] uloop_offs_i;
    logic [LW-1:0]   uloop_loop_i;
    logic [NS-1:0]   req_valid_o, req_ready_i;
    logic [NS*AW-1:0] req_addr_o;
    logic [LW-1:0]   req_loop_o;
    logic            busy_o, done_o;
    logic [IW-1:0]   iter_cnt_o;

    hwpe_ctrl_uloop_issuer #(
        .NB_STREAMS(NS), .NB_REG(NS), .REG_WIDTH(RW), .ADDR_WIDTH(AW),
        .ITER_WIDTH(IW), .NB_LOOPS(NL)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .stream_mask_i(stream_mask_i), .base_addr_i(base_addr_i),
        .uloop_clear_o(uloop_clear_o), .uloop_enable_o(uloop_enable_o),
        .uloop_valid_i(uloop_valid_i), .uloop_done_i(uloop_done_i),
        .uloop_offs_i(uloop_offs_i), .uloop_loop_i(uloop_loop_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_addr_o(req_addr_o), .req_loop_o(req_loop_o),
        .busy_o(busy_o), .done_o(done_o), .iter_cnt_o(iter_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Job description used by both the stimulus and the reference model.
    logic [AW-1:0] job_base [NS];
    logic [RW-1:0] job_offs [MAXIT][NS];
    int            job_dly  [NS];

    // Observations collected while a job runs.
    logic [AW-1:0] obs_addr [NS][$];
    int obs_done, obs_clear, obs_any_valid, proto_err, stab_err, loop_err;
    int t_last_uvalid, t_done;
    bit timed_out;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: each enabled stream issues base+offset once per iteration, in order.
    function automatic int addr_mismatches(input logic [NS-1:0] mask, input int n);
        int m;
        int exp_n;
        logic [63:0] sum;
        m = 0;
        for (int s = 0; s < NS; s++) begin
            exp_n = mask[s] ? n : 0;
            if (obs_addr[s].size() != exp_n) begin
                m++;
            end else begin
                for (int i = 0; i < exp_n; i++) begin
                    sum = {32'd0, job_base[s]} + {32'd0, job_offs[i][s]};
                    if (obs_addr[s][i] !== sum[31:0]) m++;
                end
            end
        end
        return m;
    endfunction

    task automatic randomize_job();
        for (int s = 0; s < NS; s++) begin
            job_base[s] = $urandom;
            job_dly[s]  = $urandom_range(0, 3);
            for (int i = 0; i < MAXIT; i++) job_offs[i][s] = $urandom;
        end
    endtask

    // Runs one job: behavioural uloop answers each enable with a valid one cycle
    // later; each stream sink raises ready after job_dly[s] cycles of valid.
    task automatic run_job(input logic [NS-1:0] mask, input int n_iters);
        int  it;
        bit  en_prev;
        int  vcnt [NS];
        bit  holding [NS];
        logic [AW-1:0] held [NS];
        logic [AW-1:0] a;

        for (int s = 0; s < NS; s++) begin
            obs_addr[s].delete();
            vcnt[s] = 0;
            holding[s] = 1'b0;
            held[s] = '0;
        end
        obs_done = 0; obs_clear = 0; obs_any_valid = 0;
        proto_err = 0; stab_err = 0; loop_err = 0;
        t_last_uvalid = -1; t_done = -1; timed_out = 1'b0;

        step();
        clear_i = 1'b0;
        start_i = 1'b1;
        stream_mask_i = mask;
        for (int s = 0; s < NS; s++) base_addr_i[s*AW +: AW] = job_base[s];
        step();
        start_i = 1'b0;
        stream_mask_i = 4'($urandom);
        for (int s = 0; s < NS; s++) base_addr_i[s*AW +: AW] = $urandom;

        it = 0;
        en_prev = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) step();
            uloop_valid_i = 1'b0;
            uloop_done_i  = 1'b0;
            uloop_loop_i  = 3'($urandom);
            for (int s = 0; s < NS; s++) uloop_offs_i[s*RW +: RW] = $urandom;
            if (en_prev && it < n_iters) begin
                uloop_valid_i = 1'b1;
                uloop_done_i  = (it == n_iters - 1);
                uloop_loop_i  = 3'(it % NL);
                for (int s = 0; s < NS; s++) uloop_offs_i[s*RW +: RW] = job_offs[it][s];
                it++;
                t_last_uvalid = cyc;
            end
            for (int s = 0; s < NS; s++) req_ready_i[s] = (vcnt[s] >= job_dly[s]);
            #1;
            if (uloop_clear_o) obs_clear++;
            if (uloop_enable_o && (|req_valid_o)) proto_err++;
            if (uloop_valid_i && (|req_valid_o)) proto_err++;
            if (|req_valid_o) obs_any_valid++;
            for (int s = 0; s < NS; s++) begin
                a = req_addr_o[s*AW +: AW];
                if (req_valid_o[s]) begin
                    if (holding[s] && a !== held[s]) stab_err++;
                    if (req_ready_i[s]) begin
                        if (req_loop_o !== 3'(obs_addr[s].size() % NL)) loop_err++;
                        obs_addr[s].push_back(a);
                        holding[s] = 1'b0;
                        vcnt[s] = 0;
                    end else begin
                        holding[s] = 1'b1;
                        held[s] = a;
                        vcnt[s]++;
                    end
                end else if (holding[s]) begin
                    stab_err++;
                    holding[s] = 1'b0;
                end
            end
            en_prev = uloop_enable_o;
            if (done_o) begin
                obs_done++;
                t_done = cyc;
            end else if (obs_done > 0) begin
                break;
            end
        end
        if (obs_done == 0) timed_out = 1'b1;
        uloop_valid_i = 1'b0;
        uloop_done_i  = 1'b0;
        req_ready_i   = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b1;
        stream_mask_i = '1; base_addr_i = '1;
        uloop_valid_i = 1'b0; uloop_done_i = 1'b0;
        uloop_offs_i = '1; uloop_loop_i = '0; req_ready_i = '1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({uloop_clear_o, uloop_enable_o, req_valid_o, busy_o, done_o} !== '0 ||
                req_addr_o !== '0 || iter_cnt_o !== '0 || req_loop_o !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: ctl=%b addr=%0h iter=%0d required all zero",
                         i, {uloop_clear_o, uloop_enable_o, req_valid_o, busy_o, done_o},
                         req_addr_o, iter_cnt_o);
            end
        end
        rst_i = 1'b0; start_i = 1'b0; req_ready_i = '0;
        step();
        checks++;
        if (busy_o !== 1'b0 || uloop_clear_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b uloop_clear=%b required 0 0", busy_o, uloop_clear_o);
        end
    endtask

    task automatic test_single();
        logic [AW-1:0] a0, a1;
        randomize_job();
        job_base[0] = 32'h1000; job_base[1] = 32'h2000;
        job_offs[0][0] = 32'h10; job_offs[0][1] = 32'h20;
        for (int s = 0; s < NS; s++) job_dly[s] = 0;
        run_job(4'b0011, 1);
        a0 = (obs_addr[0].size() == 1) ? obs_addr[0][0] : 32'hDEADBEEF;
        a1 = (obs_addr[1].size() == 1) ? obs_addr[1][0] : 32'hDEADBEEF;
        checks++;
        if (a0 !== 32'h1010) begin
            errors++; $display("FAIL single_addr0: got %0h required 1010", a0);
        end
        checks++;
        if (a1 !== 32'h2020) begin
            errors++; $display("FAIL single_addr1: got %0h required 2020", a1);
        end
        checks++;
        if (t_done - t_last_uvalid !== 2) begin
            errors++; $display("FAIL single_done_latency: got %0d required 2", t_done - t_last_uvalid);
        end
        checks++;
        if (iter_cnt_o !== 16'd1 || busy_o !== 1'b0 || obs_done !== 1) begin
            errors++;
            $display("FAIL single_end: iter=%0d busy=%b dones=%0d required 1 0 1", iter_cnt_o, busy_o, obs_done);
        end
    endtask

    task automatic test_backpressure();
        randomize_job();
        for (int s = 0; s < NS; s++) job_dly[s] = 0;
        job_dly[1] = 4;
        run_job(4'b0011, 3);
        checks++;
        if (addr_mismatches(4'b0011, 3) !== 0) begin
            errors++; $display("FAIL bp_addrs: mismatches %0d required 0", addr_mismatches(4'b0011, 3));
        end
        checks++;
        if (proto_err !== 0 || stab_err !== 0 || loop_err !== 0) begin
            errors++;
            $display("FAIL bp_protocol: proto=%0d stab=%0d loop=%0d required 0 0 0", proto_err, stab_err, loop_err);
        end
        checks++;
        if (iter_cnt_o !== 16'd3 || obs_done !== 1 || obs_clear !== 1) begin
            errors++;
            $display("FAIL bp_end: iter=%0d dones=%0d clears=%0d required 3 1 1", iter_cnt_o, obs_done, obs_clear);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] a0;
        randomize_job();
        job_base[0] = 32'hFFFF_FFF0;
        job_offs[0][0] = 32'h20;
        run_job(4'b0001, 1);
        a0 = (obs_addr[0].size() == 1) ? obs_addr[0][0] : 32'hDEADBEEF;
        checks++;
        if (a0 !== 32'h0000_0010) begin
            errors++; $display("FAIL wrap_addr0: got %0h required 10", a0);
        end
    endtask

    task automatic test_zero_mask();
        randomize_job();
        run_job(4'b0000, 2);
        checks++;
        if (obs_any_valid !== 0) begin
            errors++; $display("FAIL zero_mask_valids: got %0d valid cycles required 0", obs_any_valid);
        end
        checks++;
        if (obs_done !== 1 || iter_cnt_o !== 16'd2 || timed_out) begin
            errors++;
            $display("FAIL zero_mask_end: dones=%0d iter=%0d timeout=%0b required 1 2 0", obs_done, iter_cnt_o, timed_out);
        end
    endtask

    task automatic test_abort();
        logic seen_done;
        seen_done = 1'b0;
        step();
        stream_mask_i = 4'b0011; base_addr_i = '0; start_i = 1'b1;
        step(); start_i = 1'b0;
        step();
        #1;
        checks++;
        if (uloop_enable_o !== 1'b1) begin
            errors++; $display("FAIL abort_fetch_enable: got %b required 1", uloop_enable_o);
        end
        step(); uloop_valid_i = 1'b1; uloop_done_i = 1'b0; uloop_offs_i = '0;
        step(); uloop_valid_i = 1'b0; req_ready_i = 4'b0011;
        #1;
        checks++;
        if (req_valid_o !== 4'b0011) begin
            errors++; $display("FAIL abort_first_issue: got %b required 0011", req_valid_o);
        end
        step(); req_ready_i = '0;
        step(); uloop_valid_i = 1'b1;
        step(); uloop_valid_i = 1'b0;
        #1;
        checks++;
        if (req_valid_o !== 4'b0011) begin
            errors++; $display("FAIL abort_pending: got %b required 0011", req_valid_o);
        end
        step(); clear_i = 1'b1;
        #1; seen_done = done_o;
        step(); clear_i = 1'b0;
        #1;
        seen_done = seen_done | done_o;
        checks++;
        if (req_valid_o !== '0 || busy_o !== 1'b0 || uloop_enable_o !== 1'b0 || seen_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: valid=%b busy=%b en=%b done=%b required 0 0 0 0",
                     req_valid_o, busy_o, uloop_enable_o, seen_done);
        end
        checks++;
        if (iter_cnt_o !== 16'd1) begin
            errors++; $display("FAIL abort_iter_hold: got %0d required 1", iter_cnt_o);
        end
        step(); start_i = 1'b1; clear_i = 1'b1;
        step(); start_i = 1'b0; clear_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || uloop_clear_o !== 1'b0) begin
            errors++; $display("FAIL abort_start_with_clear: busy=%b uclr=%b required 0 0", busy_o, uloop_clear_o);
        end
        step(); start_i = 1'b1;
        step(); start_i = 1'b0;
        #1;
        checks++;
        if (uloop_clear_o !== 1'b1 || busy_o !== 1'b1 || iter_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL abort_restart: uclr=%b busy=%b iter=%0d required 1 1 0", uloop_clear_o, busy_o, iter_cnt_o);
        end
        step(); clear_i = 1'b1;
        step(); clear_i = 1'b0;
    endtask

    task automatic test_random();
        logic [NS-1:0] mask;
        int n;
        for (int j = 0; j < 6; j++) begin
            randomize_job();
            mask = 4'($urandom_range(0, 15));
            n = $urandom_range(1, 4);
            run_job(mask, n);
            checks++;
            if (addr_mismatches(mask, n) !== 0 || timed_out) begin
                errors++;
                $display("FAIL random_addrs job %0d mask %b n %0d: mismatches %0d timeout %0b required 0 0",
                         j, mask, n, addr_mismatches(mask, n), timed_out);
            end
            checks++;
            if (proto_err !== 0 || stab_err !== 0 || loop_err !== 0 || obs_done !== 1 ||
                obs_clear !== 1 || iter_cnt_o !== 16'(n)) begin
                errors++;
                $display("FAIL random_ctrl job %0d: proto=%0d stab=%0d loop=%0d dones=%0d clears=%0d iter=%0d required 0 0 0 1 1 %0d",
                         j, proto_err, stab_err, loop_err, obs_done, obs_clear, iter_cnt_o, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_wrap();
        test_zero_mask();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
